// File: rtl/counter_wrap_monitor.sv
// counter_wrap_monitor
// Watches a 4-bit up-counter and counts its genuine 15->0 wraps in a wider
// epoch register, so that {epoch, count} forms an extended count.
// A clear of the counter from 15 is not a wrap, and neither is a hold at 15.
// A valid/ready snapshot port returns a coherent {epoch, count} pair.
// A sticky interrupt fires once, on the edge where epoch crosses IRQ_THRESH.
module counter_wrap_monitor #(
  parameter int EPOCH_W    = 12,
  parameter int IRQ_THRESH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           count_in,
  input  logic                 cnt_clr,
  input  logic                 snap_req,
  output logic                 snap_valid,
  input  logic                 snap_ready,
  output logic [EPOCH_W+3:0]   snap_data,
  output logic [EPOCH_W-1:0]   epoch,
  output logic                 epoch_sat,
  output logic                 irq,
  input  logic                 irq_clr
);

  localparam logic [EPOCH_W-1:0] EPOCH_MAX  = {EPOCH_W{1'b1}};
  localparam logic [EPOCH_W-1:0] EPOCH_ZERO = {EPOCH_W{1'b0}};
  localparam logic [EPOCH_W-1:0] EPOCH_ONE  = {{(EPOCH_W-1){1'b0}}, 1'b1};
  localparam logic [EPOCH_W-1:0] THRESH_V   = EPOCH_W'(IRQ_THRESH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  logic [3:0]           count_prev_q;
  logic                 clr_dly_q;
  logic [EPOCH_W-1:0]   epoch_q, epoch_d;
  logic                 epoch_sat_q, epoch_sat_d;
  logic                 irq_q, irq_d;
  state_e               state_q, state_d;
  logic                 snap_valid_q, snap_valid_d;
  logic [EPOCH_W+3:0]   snap_data_q, snap_data_d;
  logic                 wrap_s;

  // A wrap is a 15 followed by 0 that was not produced by the counter's clear.
  assign wrap_s = (count_prev_q == 4'hF) && (count_in == 4'h0) && !clr_dly_q;

  // Remember last cycle's count and clear so wraps can be recognised.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_prev_q <= 4'h0;
      clr_dly_q    <= 1'b0;
    end else begin
      count_prev_q <= count_in;
      clr_dly_q    <= cnt_clr;
    end
  end

  // Epoch next state: clear has priority, then a saturating increment on wrap.
  always_comb begin
    epoch_d     = epoch_q;
    epoch_sat_d = epoch_sat_q;
    if (cnt_clr) begin
      epoch_d     = EPOCH_ZERO;
      epoch_sat_d = 1'b0;
    end else if (wrap_s && (epoch_q != EPOCH_MAX)) begin
      epoch_d     = epoch_q + EPOCH_ONE;
      epoch_sat_d = ((epoch_q + EPOCH_ONE) == EPOCH_MAX) ? 1'b1 : epoch_sat_q;
    end else begin
      epoch_d     = epoch_q;
      epoch_sat_d = (epoch_q == EPOCH_MAX) ? 1'b1 : epoch_sat_q;
    end
  end

  // Interrupt fires only on the crossing edge; a simultaneous clear loses.
  always_comb begin
    irq_d = irq_q;
    if ((epoch_d == THRESH_V) && (epoch_q != THRESH_V)) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // Snapshot handshake: capture on request in IDLE, hold until accepted.
  always_comb begin
    state_d      = state_q;
    snap_valid_d = snap_valid_q;
    snap_data_d  = snap_data_q;
    case (state_q)
      ST_IDLE: begin
        if (snap_req) begin
          snap_data_d  = {epoch_d, count_in};
          snap_valid_d = 1'b1;
          state_d      = ST_HOLD;
        end else begin
          snap_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (snap_valid_q && snap_ready) begin
          snap_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          snap_valid_d = 1'b1;
          state_d      = ST_HOLD;
        end
      end
      default: begin
        snap_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // State registers for epoch, interrupt and snapshot port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epoch_q      <= EPOCH_ZERO;
      epoch_sat_q  <= 1'b0;
      irq_q        <= 1'b0;
      state_q      <= ST_IDLE;
      snap_valid_q <= 1'b0;
      snap_data_q  <= {(EPOCH_W+4){1'b0}};
    end else begin
      epoch_q      <= epoch_d;
      epoch_sat_q  <= epoch_sat_d;
      irq_q        <= irq_d;
      state_q      <= state_d;
      snap_valid_q <= snap_valid_d;
      snap_data_q  <= snap_data_d;
    end
  end

  assign epoch      = epoch_q;
  assign epoch_sat  = epoch_sat_q;
  assign irq        = irq_q;
  assign snap_valid = snap_valid_q;
  assign snap_data  = snap_data_q;

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Bench for counter_wrap_monitor: drives a modelled 4-bit up-counter into two
// monitor instances (12-bit and 3-bit epoch) and checks every output each cycle
// against a wrap-count model, plus directed literal expectations.
module tb_counter_wrap_monitor;

  localparam int MAX_A = 4095;
  localparam int THR_A = 8;
  localparam int MAX_B = 7;
  localparam int THR_B = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] cnt;
  logic cnt_en = 1'b0;
  logic cnt_clr = 1'b0;
  logic snap_req = 1'b0;
  logic snap_ready = 1'b0;
  logic irq_clr = 1'b0;

  logic        snap_valid_a, snap_valid_b;
  logic [15:0] snap_data_a;
  logic [6:0]  snap_data_b;
  logic [11:0] epoch_a;
  logic [2:0]  epoch_b;
  logic        epoch_sat_a, epoch_sat_b, irq_a, irq_b;

  int n_cmp = 0;
  int n_bad = 0;

  counter_wrap_monitor dut_a (
    .clk(clk), .reset(reset), .count_in(cnt), .cnt_clr(cnt_clr),
    .snap_req(snap_req), .snap_valid(snap_valid_a), .snap_ready(snap_ready),
    .snap_data(snap_data_a), .epoch(epoch_a), .epoch_sat(epoch_sat_a),
    .irq(irq_a), .irq_clr(irq_clr)
  );

  counter_wrap_monitor #(.EPOCH_W(3), .IRQ_THRESH(THR_B)) dut_b (
    .clk(clk), .reset(reset), .count_in(cnt), .cnt_clr(cnt_clr),
    .snap_req(snap_req), .snap_valid(snap_valid_b), .snap_ready(snap_ready),
    .snap_data(snap_data_b), .epoch(epoch_b), .epoch_sat(epoch_sat_b),
    .irq(irq_b), .irq_clr(irq_clr)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  // wraps_m counts genuine wraps since the last clear/reset, unbounded;
  // each instance's epoch is that count clipped at its all-ones value.
  int   wraps_m, wraps_nx;
  logic pend;       // counter just rolled 15->0 by itself; monitor counts it next edge
  logic irq_a_m, irq_b_m, sv_m;
  logic [15:0] sd_a_m;
  logic [6:0]  sd_b_m;
  int ep_a_now, ep_a_nx, ep_b_now, ep_b_nx;

  function automatic int clip(input int w, input int m);
    return (w > m) ? m : w;
  endfunction

  always_comb begin
    wraps_nx = 0;
    wraps_nx = cnt_clr ? 0 : wraps_m + (pend ? 1 : 0);
    ep_a_now = clip(wraps_m, MAX_A);
    ep_a_nx  = clip(wraps_nx, MAX_A);
    ep_b_now = clip(wraps_m, MAX_B);
    ep_b_nx  = clip(wraps_nx, MAX_B);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 4'h0; pend <= 1'b0; wraps_m <= 0;
      irq_a_m <= 1'b0; irq_b_m <= 1'b0; sv_m <= 1'b0;
      sd_a_m <= 16'h0000; sd_b_m <= 7'h00;
    end else begin
      cnt     <= cnt_clr ? 4'h0 : (cnt_en ? cnt + 4'h1 : cnt);
      pend    <= (cnt == 4'hF) && cnt_en && !cnt_clr;
      wraps_m <= wraps_nx;
      irq_a_m <= (ep_a_nx == THR_A && ep_a_now != THR_A) ? 1'b1 : (irq_clr ? 1'b0 : irq_a_m);
      irq_b_m <= (ep_b_nx == THR_B && ep_b_now != THR_B) ? 1'b1 : (irq_clr ? 1'b0 : irq_b_m);
      if (!sv_m) begin
        if (snap_req) begin
          sv_m   <= 1'b1;
          sd_a_m <= {12'(ep_a_nx), cnt};
          sd_b_m <= {3'(ep_b_nx), cnt};
        end
      end else if (snap_ready) begin
        sv_m <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("epoch_a", 32'(epoch_a), 32'(clip(wraps_m, MAX_A)));
    check("sat_a", 32'(epoch_sat_a), 32'(wraps_m >= MAX_A));
    check("irq_a", 32'(irq_a), 32'(irq_a_m));
    check("snap_valid_a", 32'(snap_valid_a), 32'(sv_m));
    check("snap_data_a", 32'(snap_data_a), 32'(sd_a_m));
    check("epoch_b", 32'(epoch_b), 32'(clip(wraps_m, MAX_B)));
    check("sat_b", 32'(epoch_sat_b), 32'(wraps_m >= MAX_B));
    check("irq_b", 32'(irq_b), 32'(irq_b_m));
    check("snap_valid_b", 32'(snap_valid_b), 32'(sv_m));
    check("snap_data_b", 32'(snap_data_b), 32'(sd_b_m));
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until the counter has just rolled 15->0: the next edge is a wrap edge.
  task automatic goto_prewrap();
    int k;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (cnt != 4'h0 && k < 20);
    if (cnt != 4'h0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL prewrap_timeout: got cnt %0h expected 0", cnt);
    end
  endtask

  task automatic wrap_once();
    goto_prewrap();
    tick(1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_epoch", 32'(epoch_a), 32'd0);
    check("rst_valid", 32'(snap_valid_a), 32'd0);
    check("rst_irq", 32'(irq_a), 32'd0);

    // free run: wraps counted one edge after the counter rolls over
    cnt_en = 1'b1;
    tick(16);
    check("run16_epoch", 32'(epoch_a), 32'd0);
    tick(1);
    check("run17_epoch", 32'(epoch_a), 32'd1);
    tick(23);
    check("run40_epoch", 32'(epoch_a), 32'd2);
    check("run40_irq", 32'(irq_a), 32'd0);
    check("run40_valid", 32'(snap_valid_a), 32'd0);

    // clear while at 15: epoch cleared, no false wrap afterwards
    tick(7);
    check("pre_clr_cnt", 32'(cnt), 32'hF);
    check("pre_clr_epoch", 32'(epoch_a), 32'd2);
    cnt_clr = 1'b1; tick(1); cnt_clr = 1'b0;
    check("clr_cnt", 32'(cnt), 32'h0);
    check("clr_epoch", 32'(epoch_a), 32'd0);
    tick(1);
    check("clr_nowrap", 32'(epoch_a), 32'd0);

    // hold at 15 then resume: exactly one increment
    tick(14);
    cnt_en = 1'b0; tick(5);
    check("hold_epoch", 32'(epoch_a), 32'd0);
    cnt_en = 1'b1; tick(2);
    check("resume_epoch", 32'(epoch_a), 32'd1);
    tick(5);
    check("resume_once", 32'(epoch_a), 32'd1);

    // threshold interrupt
    repeat (6) wrap_once();
    check("pre_thr_epoch", 32'(epoch_a), 32'd7);
    check("pre_thr_irq", 32'(irq_a), 32'd0);
    goto_prewrap();
    irq_clr = 1'b1; tick(1); irq_clr = 1'b0;
    check("thr_epoch", 32'(epoch_a), 32'd8);
    check("thr_irq_setwins", 32'(irq_a), 32'd1);
    irq_clr = 1'b1; tick(1); irq_clr = 1'b0;
    check("irq_cleared", 32'(irq_a), 32'd0);
    wrap_once();
    check("no_retrigger_epoch", 32'(epoch_a), 32'd9);
    check("no_retrigger_irq", 32'(irq_a), 32'd0);

    // coherent snapshot on the 3->4 wrap edge
    cnt_clr = 1'b1; tick(1); cnt_clr = 1'b0;
    repeat (3) wrap_once();
    goto_prewrap();
    snap_req = 1'b1; tick(1); snap_req = 1'b0;
    check("snap_valid", 32'(snap_valid_a), 32'd1);
    check("snap_data_wrap", 32'(snap_data_a), 32'h0040);
    check("snap_data_b_wrap", 32'(snap_data_b), 32'h40);
    tick(2);
    snap_req = 1'b1; tick(1); snap_req = 1'b0;
    tick(3);
    check("snap_hold_valid", 32'(snap_valid_a), 32'd1);
    check("snap_hold_data", 32'(snap_data_a), 32'h0040);
    snap_ready = 1'b1; snap_req = 1'b1; tick(1);
    snap_ready = 1'b0; snap_req = 1'b0;
    check("snap_done", 32'(snap_valid_a), 32'd0);
    snap_req = 1'b1; tick(1); snap_req = 1'b0;
    check("snap2_valid", 32'(snap_valid_a), 32'd1);
    check("snap2_data", 32'(snap_data_a), 32'h0048);

    // saturation of the 3-bit instance
    repeat (3) wrap_once();
    check("sat_b_epoch", 32'(epoch_b), 32'd7);
    check("sat_b_flag", 32'(epoch_sat_b), 32'd1);
    wrap_once();
    check("sat_b_drop", 32'(epoch_b), 32'd7);
    check("sat_a_epoch", 32'(epoch_a), 32'd8);
    check("hold_pending", 32'(snap_valid_a), 32'd1);

    // asynchronous reset during HOLD
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 32'(snap_valid_a), 32'd0);
    check("arst_epoch", 32'(epoch_a), 32'd0);
    check("arst_epoch_b", 32'(epoch_b), 32'd0);
    check("arst_sat_b", 32'(epoch_sat_b), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick(3);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
